spi_master_frame_queue: RTL and testbench

Frame queue and sequencer in front of the 4-wire SPI master. Buffers outbound words in a TX FIFO, issues one master frame per word, and captures each frame's returned MISO word in an RX FIFO. Upstream logic gets valid/ready streams instead of frame-by-frame master handshaking. RX space is reserved before a frame starts, so returned words are never lost.

---
 rtl/spi_master_frame_queue.sv | 117 +++++++++++
 tb/tb_spi_master_frame_queue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_frame_queue.sv
// Frame queue/sequencer in front of the SPI master: TX FIFO -> one frame per word -> RX FIFO.
// Define SPI_FRAME_QUEUE_TX_ONLY_EN to drop the RX FIFO and its credit gating.
module spi_master_frame_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tx_data,
  input  logic                  s_tx_valid,
  output logic                  s_tx_ready,
  output logic [DATA_WIDTH-1:0] m_rx_data,
  output logic                  m_rx_valid,
  input  logic                  m_rx_ready,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic                  spi_start,
  input  logic                  spi_ready,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  input  logic                  spi_rx_valid,
  output logic [LVL_W-1:0]      tx_level,
  output logic [LVL_W-1:0]      rx_level,
  output logic                  err_unexp_rx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT_DONE = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]         tx_wr, tx_rd;
  logic                  tx_push, tx_pop, rx_credit, launch;

  assign s_tx_ready = (tx_level != FULL);
  assign tx_push    = s_tx_valid & s_tx_ready;
  assign tx_pop     = (state == START);
  assign spi_start  = (state == START);
  assign launch     = (state == IDLE) && (tx_level != '0) && spi_ready && rx_credit;

  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wr] <= s_tx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_level <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + 1'b1;
        2'b01:   tx_level <= tx_level - 1'b1;
        default: ;
      endcase
    end
  end

  // spi_tx_data is captured on entry to START so it is valid alongside spi_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      spi_tx_data  <= '0;
      err_unexp_rx <= 1'b0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          state       <= START;
          spi_tx_data <= tx_mem[tx_rd];
        end
        START:     state <= WAIT_DONE;
        WAIT_DONE: if (spi_rx_valid) state <= IDLE;
        default:   state <= IDLE;
      endcase
      if (spi_rx_valid && state != WAIT_DONE) err_unexp_rx <= 1'b1;
    end
  end

`ifdef SPI_FRAME_QUEUE_TX_ONLY_EN
  logic unused_rx;
  assign unused_rx  = ^{spi_rx_data, m_rx_ready};
  assign rx_credit  = 1'b1;
  assign m_rx_valid = 1'b0;
  assign m_rx_data  = '0;
  assign rx_level   = '0;
`else
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]         rx_wr, rx_rd;
  logic                  rx_write, rx_read;

  assign rx_write   = (state == WAIT_DONE) && spi_rx_valid;
  assign rx_read    = m_rx_valid & m_rx_ready;
  assign rx_credit  = (rx_level != FULL);
  assign m_rx_valid = (rx_level != '0);
  // Head word is masked while empty so stale storage never shows on the port.
  assign m_rx_data  = m_rx_valid ? rx_mem[rx_rd] : '0;

  always_ff @(posedge clk)
    if (rx_write) rx_mem[rx_wr] <= spi_rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_level <= '0;
    end else begin
      if (rx_write) rx_wr <= rx_wr + 1'b1;
      if (rx_read)  rx_rd <= rx_rd + 1'b1;
      case ({rx_write, rx_read})
        2'b10:   rx_level <= rx_level + 1'b1;
        2'b01:   rx_level <= rx_level - 1'b1;
        default: ;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_spi_master_frame_queue.sv
// Bench for spi_master_frame_queue: emulated SPI master, queue-based reference model, directed + random traffic.
module tb_spi_master_frame_queue;
  localparam int DW = 16;
  localparam int D  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tx_data = '0;
  logic          s_tx_valid = 1'b0;
  logic          s_tx_ready;
  logic [DW-1:0] m_rx_data;
  logic          m_rx_valid;
  logic          m_rx_ready = 1'b0;
  logic [DW-1:0] spi_tx_data;
  logic          spi_start;
  logic          spi_ready;
  logic [DW-1:0] spi_rx_data;
  logic          spi_rx_valid;
  logic [LW-1:0] tx_level, rx_level;
  logic          err_unexp_rx;

  spi_master_frame_queue #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
    .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready),
    .spi_tx_data(spi_tx_data), .spi_start(spi_start), .spi_ready(spi_ready),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .tx_level(tx_level), .rx_level(rx_level), .err_unexp_rx(err_unexp_rx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Master emulation: accepts spi_start, answers after a latency with loopback or random data.
  int lat_fixed = -1;
  bit hold_ready = 1'b0;
  bit loopback = 1'b1;
  int unexp_req = 0;

  initial begin : master
    bit busy;
    int cnt;
    int unexp_ack;
    logic [DW-1:0] cap;
    busy = 0; cnt = 0; unexp_ack = 0; cap = '0;
    spi_ready = 1'b1; spi_rx_valid = 1'b0; spi_rx_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && spi_start && !busy) begin
        busy = 1;
        cap  = spi_tx_data;
        cnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 12));
      end
      @(posedge clk); #1;
      spi_rx_valid = 1'b0;
      if (rst) busy = 0;
      else if (busy) begin
        if (cnt == 0) begin
          spi_rx_valid = 1'b1;
          spi_rx_data  = loopback ? cap : DW'($urandom);
          busy = 0;
        end else cnt--;
      end else if (unexp_ack != unexp_req) begin
        spi_rx_valid = 1'b1;
        spi_rx_data  = 16'hDEAD;
        unexp_ack++;
      end
      spi_ready = !busy && !hold_ready;
    end
  end

  // Reference model: word queues plus a frame phase (0 idle, 1 launching, 2 awaiting result).
  logic [DW-1:0] txq[$], rxq[$], starts[$];
  int phase = 0;
  logic [DW-1:0] m_tx = '0;
  bit m_err = 1'b0;

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        txq.delete(); rxq.delete();
        phase = 0; m_tx = '0; m_err = 1'b0;
      end else begin
        bit acc, rd, can_go;
        int nph;
        acc    = s_tx_valid && (txq.size() != D);
        rd     = m_rx_ready && (rxq.size() != 0);
        can_go = (txq.size() != 0) && spi_ready && (rxq.size() != D);
        nph    = phase;
        if (phase == 0 && can_go) begin nph = 1; m_tx = txq[0]; end
        if (phase == 1) begin nph = 2; void'(txq.pop_front()); end
        if (rd) void'(rxq.pop_front());
        if (spi_rx_valid) begin
          if (phase == 2) begin rxq.push_back(spi_rx_data); nph = 0; end
          else m_err = 1'b1;
        end
        if (acc) txq.push_back(s_tx_data);
        phase = nph;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("s_tx_ready", 32'(s_tx_ready), 32'(txq.size() != D));
        chk("tx_level", 32'(tx_level), txq.size());
        chk("rx_level", 32'(rx_level), rxq.size());
        chk("m_rx_valid", 32'(m_rx_valid), 32'(rxq.size() != 0));
        if (rxq.size() != 0) chk("m_rx_data", 32'(m_rx_data), 32'(rxq[0]));
        chk("spi_start", 32'(spi_start), 32'(phase == 1));
        chk("spi_tx_data", 32'(spi_tx_data), 32'(m_tx));
        chk("err_unexp_rx", 32'(err_unexp_rx), 32'(m_err));
        if (spi_start) starts.push_back(spi_tx_data);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    s_tx_valid = 1'b1; s_tx_data = d;
    while (!s_tx_ready && n < 400) begin tick(); n++; end
    chk("push_accept", 32'(s_tx_ready), 1);
    tick();
    s_tx_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (!(tx_level == 0 && rx_level == 0 && phase == 0) && n < 2000) begin tick(); n++; end
    chk("drain", 32'(tx_level == 0 && rx_level == 0 && phase == 0), 1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_s_tx_ready"}, 32'(s_tx_ready), 1);
    chk({nm, "_m_rx_valid"}, 32'(m_rx_valid), 0);
    chk({nm, "_m_rx_data"}, 32'(m_rx_data), 0);
    chk({nm, "_spi_start"}, 32'(spi_start), 0);
    chk({nm, "_spi_tx_data"}, 32'(spi_tx_data), 0);
    chk({nm, "_tx_level"}, 32'(tx_level), 0);
    chk({nm, "_rx_level"}, 32'(rx_level), 0);
    chk({nm, "_err"}, 32'(err_unexp_rx), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : main
    int n, base, nstart;
    logic [DW-1:0] sd;
    repeat (3) @(posedge clk);
    #2;
    chk_reset("rst");
    rst = 1'b0;
    tick();

    // Single loopback word: start one cycle after the push edge, single-cycle pulse
    lat_fixed = 3;
    push(16'hA5C3);
    chk("one_lat0", 32'(spi_start), 0);
    tick();
    chk("one_start", 32'(spi_start), 1);
    chk("one_txdata", 32'(spi_tx_data), 32'h0000A5C3);
    tick();
    chk("one_pulse", 32'(spi_start), 0);
    chk("one_pop", 32'(tx_level), 0);
    nstart = 0;
    for (int i = 0; i < 20; i++) begin
      if (spi_start) nstart++;
      tick();
    end
    chk("one_nstart", nstart, 0);
    chk("one_rx_valid", 32'(m_rx_valid), 1);
    chk("one_rx_data", 32'(m_rx_data), 32'h0000A5C3);
    chk("one_rx_level", 32'(rx_level), 1);
    m_rx_ready = 1'b1; tick(); m_rx_ready = 1'b0;
    chk("one_rx_read", 32'(rx_level), 0);

    // TX back-pressure with the master held busy
    lat_fixed = -1; hold_ready = 1'b1; m_rx_ready = 1'b1;
    tick(); tick();
    base = starts.size();
    for (int i = 1; i <= 8; i++) push(DW'(i));
    chk("bp_level", 32'(tx_level), 8);
    chk("bp_ready", 32'(s_tx_ready), 0);
    s_tx_valid = 1'b1; s_tx_data = 16'h0009;
    repeat (6) tick();
    chk("bp_hold", 32'(tx_level), 8);
    chk("bp_nostart", starts.size(), base);
    hold_ready = 1'b0;
    n = 0;
    while (!s_tx_ready && n < 200) begin tick(); n++; end
    chk("bp_ninth", 32'(s_tx_ready), 1);
    tick(); s_tx_valid = 1'b0;
    wait_idle();
    chk("bp_count", starts.size() - base, 9);
    for (int i = 0; i < 9; i++)
      if (base + i < starts.size()) chk("bp_order", 32'(starts[base + i]), i + 1);

    // RX credit: 8 frames fill RX, the 9th waits in TX until one read
    m_rx_ready = 1'b0;
    base = starts.size();
    for (int i = 1; i <= 9; i++) push(DW'(16'h0100 + i));
    n = 0;
    while (!(rx_level == 8 && tx_level == 1) && n < 600) begin tick(); n++; end
    chk("cr_rx_full", 32'(rx_level), 8);
    chk("cr_tx_left", 32'(tx_level), 1);
    for (int i = 0; i < 10; i++) begin chk("cr_nostart", 32'(spi_start), 0); tick(); end
    m_rx_ready = 1'b1; tick(); m_rx_ready = 1'b0;
    n = 0;
    while (!spi_start && n < 5) begin tick(); n++; end
    chk("cr_release", 32'(spi_start), 1);
    chk("cr_release_data", 32'(spi_tx_data), 32'h00000109);
    m_rx_ready = 1'b1;
    wait_idle();
    chk("cr_count", starts.size() - base, 9);

    // Simultaneous RX write and read at level 3
    m_rx_ready = 1'b0; lat_fixed = 4;
    for (int i = 0; i < 4; i++) push(DW'(16'h3000 + i));
    n = 0;
    while (rx_level != 3 && n < 300) begin tick(); n++; end
    n = 0;
    while (!spi_rx_valid && n < 50) begin tick(); n++; end
    chk("sim_pre", 32'(rx_level), 3);
    chk("sim_rxv", 32'(spi_rx_valid), 1);
    m_rx_ready = 1'b1; tick(); m_rx_ready = 1'b0;
    chk("sim_level", 32'(rx_level), 3);
    chk("sim_head", 32'(m_rx_data), 32'h00003001);
    m_rx_ready = 1'b1;
    wait_idle();

    // Randomized traffic against the model
    lat_fixed = -1; loopback = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      s_tx_valid = 1'($urandom_range(0, 1));
      s_tx_data  = DW'($urandom);
      m_rx_ready = ((c / 500) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      hold_ready = ($urandom_range(0, 15) == 0);
      tick();
    end
    s_tx_valid = 1'b0; hold_ready = 1'b0; m_rx_ready = 1'b1;
    wait_idle();

    // Unexpected RX result while idle with one word held in RX
    loopback = 1'b1; m_rx_ready = 1'b0; lat_fixed = 2;
    push(16'h1234);
    n = 0;
    while (rx_level != 1 && n < 50) begin tick(); n++; end
    unexp_req++;
    tick(); tick();
    chk("ux_err", 32'(err_unexp_rx), 1);
    chk("ux_rx_level", 32'(rx_level), 1);
    chk("ux_rx_data", 32'(m_rx_data), 32'h00001234);
    repeat (10) tick();
    chk("ux_sticky", 32'(err_unexp_rx), 1);
    m_rx_ready = 1'b1;
    wait_idle();
    chk("ux_sticky2", 32'(err_unexp_rx), 1);

    // Reset while awaiting a frame result with four words queued
    lat_fixed = 1000;
    for (int i = 0; i < 5; i++) push(DW'(16'h5000 + i));
    tick();
    chk("rm_tx_level", 32'(tx_level), 4);
    chk("rm_waiting", 32'(phase), 2);
    rst = 1'b1;
    tick();
    chk_reset("rm");
    tick();
    rst = 1'b0; lat_fixed = -1;
    for (int i = 0; i < 20; i++) begin chk("rm_no_rx", 32'(m_rx_valid), 0); tick(); end
    push(16'h7777);
    n = 0;
    while (!m_rx_valid && n < 100) begin tick(); n++; end
    chk("rm_new_valid", 32'(m_rx_valid), 1);
    chk("rm_new_data", 32'(m_rx_data), 32'h00007777);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
